// File: rtl/instruction_pkg.sv
// Shared memory-op encodings, memory-stage state type and alignment helper.
package instruction_pkg;

    typedef logic [2:0] mem_op_t;

    // Load and store funct3 values overlap in the low bits; stores never set bit 2.
    localparam mem_op_t F3_LB  = 3'b000;
    localparam mem_op_t F3_LH  = 3'b001;
    localparam mem_op_t F3_LW  = 3'b010;
    localparam mem_op_t F3_LBU = 3'b100;
    localparam mem_op_t F3_LHU = 3'b101;
    localparam mem_op_t F3_SB  = 3'b000;
    localparam mem_op_t F3_SH  = 3'b001;
    localparam mem_op_t F3_SW  = 3'b010;

    localparam logic [3:0] MINST_NONE = 4'b1100;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} mem_state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and extract/extend for loads.
// Purely combinational, no flow control.
module mem_align
    import instruction_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_store_i,
    input  mem_op_t         op_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] sdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] ldata_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = sdata_i;
        if (is_store_i) begin
            case ({1'b0, op_i[1:0]})
                F3_SB: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {(XLEN/8){sdata_i[7:0]}};
                end
                F3_SH: begin
                    be_o    = 4'b0011 << addr_lo_i;
                    wdata_o = {(XLEN/16){sdata_i[15:0]}};
                end
                F3_SW:   be_o = 4'b1111;
                default: be_o = 4'b1111;
            endcase
        end
    end

    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        case (op_i)
            F3_LB:   ldata_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   ldata_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LBU:  ldata_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  ldata_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_LW:   ldata_o = shifted;
            default: ldata_o = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory stage: one outstanding data-memory load/store, aligned write-back.
// Load latency >= 3 cycles; stalls upstream via hazard_m, holds dreq_* until dreq_ready.
module memory_access
    import instruction_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      minst,
    input  logic            rdm_v,
    input  logic [4:0]      rd_x,
    input  logic [XLEN-1:0] addr_x,
    input  logic [XLEN-1:0] sdata_x,
    output logic            hazard_m,
    output logic            dreq_v,
    input  logic            dreq_ready,
    output logic            dreq_we,
    output logic [3:0]      dreq_be,
    output logic [XLEN-1:0] dreq_addr,
    output logic [XLEN-1:0] dreq_wdata,
    input  logic            dresp_v,
    input  logic [XLEN-1:0] dresp_rdata,
    output logic            wb_v,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            err_m
);

    localparam int CW = 16;

    mem_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    mem_op_t         op_q;
    logic            we_q, rdm_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] addr_q, sdata_q;
    logic            wb_v_q, wb_v_d, err_q, err_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            cmd_vld, cmd_misal, latch_en;
    mem_op_t         cmd_op;
    logic [3:0]      be;
    logic [XLEN-1:0] ldata;

    assign cmd_vld   = reset && (state_q == S_IDLE) && (minst[3:2] != MINST_NONE[3:2]);
    assign cmd_op    = minst[3] ? {1'b0, minst[1:0]} : minst[2:0];
    assign cmd_misal = misaligned(minst[1:0], addr_x[1:0]);

    mem_align #(.XLEN(XLEN)) u_align (
        .is_store_i (we_q),
        .op_i       (op_q),
        .addr_lo_i  (addr_q[1:0]),
        .sdata_i    (sdata_q),
        .rdata_i    (dresp_rdata),
        .be_o       (be),
        .wdata_o    (dreq_wdata),
        .ldata_o    (ldata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wb_v_d    = 1'b0;
        wb_data_d = wb_data_q;
        err_d     = 1'b0;
        latch_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_vld) begin
                    if (cmd_misal) begin
                        err_d = 1'b1;
                    end else begin
                        latch_en = 1'b1;
                        state_d  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = '0;
                if (dreq_ready) state_d = S_RESP;
            end
            S_RESP: begin
                if (dresp_v) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (!we_q && rdm_q && (rd_q != 5'd0)) begin
                        wb_v_d    = 1'b1;
                        wb_data_d = ldata;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            we_q      <= 1'b0;
            rdm_q     <= 1'b0;
            rd_q      <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            wb_v_q    <= 1'b0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_v_q    <= wb_v_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
            if (latch_en) begin
                op_q    <= cmd_op;
                we_q    <= minst[3];
                rdm_q   <= rdm_v;
                rd_q    <= rd_x;
                addr_q  <= addr_x;
                sdata_q <= sdata_x;
            end
        end
    end

    assign hazard_m  = (state_q != S_IDLE) || cmd_vld;
    assign dreq_v    = (state_q == S_REQ);
    assign dreq_we   = dreq_v && we_q;
    assign dreq_be   = dreq_v ? be : 4'b0000;
    assign dreq_addr = {addr_q[XLEN-1:2], 2'b00};
    assign wb_v      = wb_v_q;
    assign wb_rd     = rd_q;
    assign wb_data   = wb_data_q;
    assign err_m     = err_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed plus randomized checks of memory_access against a behavioural model.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  minst;
    logic        rdm_v;
    logic [4:0]  rd_x;
    logic [31:0] addr_x, sdata_x;
    logic        hazard_m, dreq_v, dreq_ready, dreq_we;
    logic [3:0]  dreq_be;
    logic [31:0] dreq_addr, dreq_wdata;
    logic        dresp_v;
    logic [31:0] dresp_rdata;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_access #(.XLEN(32), .TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .minst       (minst),
        .rdm_v       (rdm_v),
        .rd_x        (rd_x),
        .addr_x      (addr_x),
        .sdata_x     (sdata_x),
        .hazard_m    (hazard_m),
        .dreq_v      (dreq_v),
        .dreq_ready  (dreq_ready),
        .dreq_we     (dreq_we),
        .dreq_be     (dreq_be),
        .dreq_addr   (dreq_addr),
        .dreq_wdata  (dreq_wdata),
        .dresp_v     (dresp_v),
        .dresp_rdata (dresp_rdata),
        .wb_v        (wb_v),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .err_m       (err_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input logic st, input logic [2:0] f3, input int a);
        logic [3:0] be;
        be = 4'b0000;
        if (!st) return 4'hF;
        for (int i = 0; i < 4; i++) be[i] = (i >= a) && (i < a + op_size(f3));
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] s);
        logic [31:0] w;
        int n;
        n = op_size(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = s[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int a, input logic [31:0] raw);
        logic [31:0] w;
        int v;
        w = raw >> (8 * a);
        case (f3)
            3'b000: begin v = int'(w & 32'hFF);   if (v >= 128)   v -= 256;   return 32'(v); end
            3'b001: begin v = int'(w & 32'hFFFF); if (v >= 32768) v -= 65536; return 32'(v); end
            3'b100: return w & 32'hFF;
            3'b101: return w & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // Starts and ends just after a rising edge with the DUT idle.
    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input logic rdm,
                          input logic [4:0] rd, input int dr, input int dp);
        int a, hs;
        logic exp_wb;
        a  = int'(addr[1:0]);
        hs = 0;
        minst   = st ? {2'b10, f3[1:0]} : {1'b0, f3};
        rdm_v   = rdm;
        rd_x    = rd;
        addr_x  = addr;
        sdata_x = sdata;
        @(negedge clk);
        chk("hazard_accept", 32'(hazard_m), 32'd1);
        chk("dreq_v_accept", 32'(dreq_v), 32'd0);
        next_cycle();
        minst   = 4'b1100;
        rdm_v   = 1'($urandom);
        rd_x    = 5'($urandom);
        addr_x  = $urandom;
        sdata_x = $urandom;
        if ((a % op_size(f3)) != 0) begin
            @(negedge clk);
            chk("misal_err", 32'(err_m), 32'd1);
            chk("misal_dreq_v", 32'(dreq_v), 32'd0);
            chk("misal_wb_v", 32'(wb_v), 32'd0);
            chk("misal_hazard", 32'(hazard_m), 32'd0);
            next_cycle();
            @(negedge clk);
            chk("misal_err_drop", 32'(err_m), 32'd0);
            chk("misal_dreq_v2", 32'(dreq_v), 32'd0);
            next_cycle();
            return;
        end
        for (int k = 0; k <= dr; k++) begin
            dreq_ready = (k == dr);
            @(negedge clk);
            chk("req_v", 32'(dreq_v), 32'd1);
            chk("req_addr", dreq_addr, {addr[31:2], 2'b00});
            chk("req_be", 32'(dreq_be), 32'(model_be(st, f3, a)));
            chk("req_we", 32'(dreq_we), 32'(st));
            if (st) chk("req_wdata", dreq_wdata, model_wdata(f3, sdata));
            chk("req_hazard", 32'(hazard_m), 32'd1);
            if (dreq_v && dreq_ready) hs++;
            next_cycle();
        end
        dreq_ready = 1'b0;
        for (int r = 0; r <= dp; r++) begin
            dresp_v     = (r == dp);
            dresp_rdata = (r == dp) ? rdata : $urandom;
            @(negedge clk);
            chk("resp_dreq_v", 32'(dreq_v), 32'd0);
            chk("resp_hazard", 32'(hazard_m), 32'd1);
            chk("resp_wb_v", 32'(wb_v), 32'd0);
            if (dreq_v && dreq_ready) hs++;
            next_cycle();
        end
        dresp_v = 1'b0;
        exp_wb  = !st && rdm;
        @(negedge clk);
        chk("wb_v", 32'(wb_v), 32'(exp_wb));
        if (exp_wb) begin
            chk("wb_rd", 32'(wb_rd), 32'(rd));
            chk("wb_data", wb_data, model_load(f3, a, rdata));
        end
        chk("done_hazard", 32'(hazard_m), 32'd0);
        chk("done_err", 32'(err_m), 32'd0);
        chk("req_count", 32'(hs), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("wb_v_pulse", 32'(wb_v), 32'd0);
        next_cycle();
    endtask

    initial begin
        logic [3:0] optab [8];
        logic [3:0] e;
        logic [4:0] rd;
        optab = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010};

        reset = 1'b0; minst = 4'b1100; rdm_v = 1'b0; rd_x = 5'd0; addr_x = '0; sdata_x = '0;
        dreq_ready = 1'b0; dresp_v = 1'b0; dresp_rdata = '0;
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_hazard", 32'(hazard_m), 32'd0);
        chk("rst_dreq_v", 32'(dreq_v), 32'd0);
        chk("rst_we", 32'(dreq_we), 32'd0);
        chk("rst_be", 32'(dreq_be), 32'd0);
        chk("rst_addr", dreq_addr, 32'd0);
        chk("rst_wdata", dreq_wdata, 32'd0);
        chk("rst_wb_v", 32'(wb_v), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err", 32'(err_m), 32'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'h12345678, 1'b1, 5'd5, 0, 0);
        do_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80000000, 1'b1, 5'd6, 0, 0);
        do_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80000000, 1'b1, 5'd7, 0, 0);
        do_txn(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'hDEADDEAD, 1'b0, 5'd0, 0, 0);
        do_txn(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 1'b0, 5'd0, 4, 1);
        do_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 5'd9, 0, 0);

        // Response never arrives: timeout after 8 cycles waiting.
        minst = 4'b0010; rdm_v = 1'b1; rd_x = 5'd3; addr_x = 32'h200;
        @(negedge clk);
        chk("to_hazard_accept", 32'(hazard_m), 32'd1);
        next_cycle();
        minst = 4'b1100; dreq_ready = 1'b1;
        @(negedge clk);
        chk("to_dreq_v", 32'(dreq_v), 32'd1);
        next_cycle();
        dreq_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("to_wait_err", 32'(err_m), 32'd0);
            chk("to_wait_hazard", 32'(hazard_m), 32'd1);
            next_cycle();
        end
        @(negedge clk);
        chk("to_err", 32'(err_m), 32'd1);
        chk("to_hazard_drop", 32'(hazard_m), 32'd0);
        chk("to_wb_v", 32'(wb_v), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("to_err_drop", 32'(err_m), 32'd0);
        next_cycle();

        // Reset while waiting for the response; late response must be ignored.
        minst = 4'b0010; rdm_v = 1'b1; rd_x = 5'd4; addr_x = 32'h300;
        next_cycle();
        minst = 4'b1100; dreq_ready = 1'b1;
        next_cycle();
        dreq_ready = 1'b0;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rm_hazard", 32'(hazard_m), 32'd0);
        chk("rm_dreq_v", 32'(dreq_v), 32'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        dresp_v = 1'b1; dresp_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        chk("rm_stray_hazard", 32'(hazard_m), 32'd0);
        next_cycle();
        dresp_v = 1'b0;
        @(negedge clk);
        chk("rm_stray_wb_v", 32'(wb_v), 32'd0);
        chk("rm_stray_dreq_v", 32'(dreq_v), 32'd0);
        chk("rm_stray_err", 32'(err_m), 32'd0);
        next_cycle();

        for (int n = 0; n < 40; n++) begin
            e  = optab[$urandom_range(0, 7)];
            rd = 5'($urandom);
            do_txn(e[3], e[2:0], $urandom, $urandom, $urandom,
                   (rd != 5'd0) && 1'($urandom), rd,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
